rtc_time_counter: RTL and testbench
===================================

Name: rtc_time_counter

Overview:
- Parametrised next-generation BCD time-of-day counter for the alarm clock datapath.
- Holds hours:minutes and optionally seconds as BCD digits.
- Supports 24-hour or 12-hour AM/PM operation, validated parallel load, and minute/day-wrap pulses.
- Fed by the timegen tick; feeds the display driver and alarm comparator.

Parameters:
- SECONDS_EN, 1: 1 = tick advances seconds, seconds digits kept. 0 = tick advances minutes directly; seconds outputs and new_sec inputs unused.
- HOUR_24, 1: 1 = 24-hour mode (00-23). 0 = 12-hour mode (01-12, plus pm flag).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  advance-one-unit strobe; one step per cycle sampled high.
- load_new_c  input  1  load request for new_* inputs.
- new_ms_hr, new_ls_hr, new_ms_min, new_ls_min, new_ms_sec, new_ls_sec  input  4 each  BCD load digits.
- new_pm  input  1  PM flag for load (12-hour mode only).
- ms_hr, ls_hr, ms_min, ls_min, ms_sec, ls_sec  output  4 each  current BCD time, registered.
- pm  output  1  PM flag; constant 0 when HOUR_24=1.
- minute_pulse  output  1  one-cycle pulse when minutes advance due to tick.
- day_wrap  output  1  one-cycle pulse on midnight rollover.
- load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset, synchronous and dominant over everything:
  - HOUR_24=1: outputs 00:00:00.
  - HOUR_24=0: outputs 12:00:00 with pm=0.
  - All pulses 0.
- Priority: reset > load_new_c > tick. Load and tick in the same cycle: load wins, tick discarded (not deferred).
- Latency: every change is visible the cycle after the sampled strobe. Pulses are registered and coincide with the new time value.
- Load validation:
  - Each ls digit must be ≤9; ms_min ≤5; ms_sec ≤5 (SECONDS_EN=1 only).
  - Hours: 00-23 in 24-hour mode; 01-12 in 12-hour mode.
  - Valid load: all digits and pm copied; seconds forced to 00 when SECONDS_EN=0.
  - Invalid load: state unchanged, load_err=1 for one cycle.
  - Valid load never pulses minute_pulse or day_wrap.
- Tick with SECONDS_EN=1:
  - ls_sec 0-9 carries into ms_sec 0-5.
  - 59 rolls to 00 and advances minutes; minute_pulse=1 on that update.
- Tick with SECONDS_EN=0: advances minutes directly; minute_pulse=1 on every tick.
- Minutes: ls_min 0-9 carries into ms_min 0-5; 59 rolls to 00 and advances hours.
- Hours, 24-hour mode: 23 advances to 00; day_wrap=1.
- Hours, 12-hour mode:
  - 11 advances to 12 and toggles pm.
  - 12 advances to 01, pm unchanged.
  - day_wrap=1 only on the 11 PM -> 12 AM transition.
- Arithmetic:
  - Pure BCD; no digit ever leaves its legal range from legal state.
  - Full carry chain resolves in one cycle (e.g. 23:59:59 -> 00:00:00 in one step).
- Reset mid-carry or mid-load: reset wins that cycle; pending pulses are suppressed.

Test Plan:
- Reset held 5 cycles, HOUR_24=1 -> 00:00:00, all pulses 0. With HOUR_24=0 -> 12:00:00, pm=0.
- Load 23:59:58, then 2 ticks -> 23:59:59, then 00:00:00. day_wrap and minute_pulse high exactly on the second update cycle.
- HOUR_24=0: load 11:59:59 pm=0, 1 tick -> 12:00:00 pm=1, no day_wrap. Load 11:59:59 pm=1, 1 tick -> 12:00:00 pm=0, day_wrap=1. Load 12:59:59, 1 tick -> 01:00:00.
- Invalid loads (ls_min=4'hF, ms_min=6, hour 24 in 24-hour mode, hour 00 in 12-hour mode) -> time unchanged, load_err one-cycle pulse each.
- load_new_c and tick asserted together with load 10:15:00 -> 10:15:00 exactly, next tick -> 10:15:01.
- SECONDS_EN=0: load 09:59, tick -> 10:00 with minute_pulse=1, seconds outputs 00. Reset asserted same cycle as tick -> reset value, no pulses.

Source files
------------

// File: rtl/rtc_time_counter.sv
// BCD time-of-day counter (hh:mm[:ss]) with 24h or 12h AM/PM operation,
// validated parallel load, and registered minute / day-wrap / load-error pulses.
module rtc_time_counter #(
    parameter bit SECONDS_EN = 1'b1,
    parameter bit HOUR_24    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load_new_c,
    input  logic [3:0] new_ms_hr,
    input  logic [3:0] new_ls_hr,
    input  logic [3:0] new_ms_min,
    input  logic [3:0] new_ls_min,
    input  logic [3:0] new_ms_sec,
    input  logic [3:0] new_ls_sec,
    input  logic       new_pm,
    output logic [3:0] ms_hr,
    output logic [3:0] ls_hr,
    output logic [3:0] ms_min,
    output logic [3:0] ls_min,
    output logic [3:0] ms_sec,
    output logic [3:0] ls_sec,
    output logic       pm,
    output logic       minute_pulse,
    output logic       day_wrap,
    output logic       load_err
);

    localparam int unsigned DIG_W = 4;

    // Midnight shows as 00 in 24-hour mode and as 12 AM in 12-hour mode.
    localparam logic [DIG_W-1:0] RST_MS_HR = HOUR_24 ? DIG_W'(0) : DIG_W'(1);
    localparam logic [DIG_W-1:0] RST_LS_HR = HOUR_24 ? DIG_W'(0) : DIG_W'(2);

    logic [DIG_W-1:0] r_ms_hr, r_ls_hr, r_ms_min, r_ls_min, r_ms_sec, r_ls_sec;
    logic             r_pm, r_minute_pulse, r_day_wrap, r_load_err;

    logic [DIG_W-1:0] w_nxt_ms_hr, w_nxt_ls_hr, w_nxt_ms_min, w_nxt_ls_min;
    logic [DIG_W-1:0] w_nxt_ms_sec, w_nxt_ls_sec;
    logic             w_nxt_pm, w_nxt_minute_pulse, w_nxt_day_wrap, w_nxt_load_err;
    logic             w_min_step, w_hr_step;

    logic w_sec_ok, w_min_ok, w_hr24_ok, w_hr12_ok, w_load_ok;

    // Load digit validation; seconds digits only matter when they are kept.
    assign w_sec_ok  = !SECONDS_EN ||
                       ((new_ms_sec <= DIG_W'(5)) && (new_ls_sec <= DIG_W'(9)));
    assign w_min_ok  = (new_ms_min <= DIG_W'(5)) && (new_ls_min <= DIG_W'(9));
    assign w_hr24_ok = ((new_ms_hr <= DIG_W'(1)) && (new_ls_hr <= DIG_W'(9))) ||
                       ((new_ms_hr == DIG_W'(2)) && (new_ls_hr <= DIG_W'(3)));
    assign w_hr12_ok = ((new_ms_hr == DIG_W'(0)) && (new_ls_hr != DIG_W'(0)) &&
                        (new_ls_hr <= DIG_W'(9))) ||
                       ((new_ms_hr == DIG_W'(1)) && (new_ls_hr <= DIG_W'(2)));
    assign w_load_ok = w_sec_ok && w_min_ok && (HOUR_24 ? w_hr24_ok : w_hr12_ok);

    // Next-state: load beats tick; the whole sec->min->hour carry chain settles here.
    always_comb begin
        w_nxt_ms_hr        = r_ms_hr;
        w_nxt_ls_hr        = r_ls_hr;
        w_nxt_ms_min       = r_ms_min;
        w_nxt_ls_min       = r_ls_min;
        w_nxt_ms_sec       = r_ms_sec;
        w_nxt_ls_sec       = r_ls_sec;
        w_nxt_pm           = r_pm;
        w_nxt_minute_pulse = 1'b0;
        w_nxt_day_wrap     = 1'b0;
        w_nxt_load_err     = 1'b0;
        w_min_step         = 1'b0;
        w_hr_step          = 1'b0;

        if (load_new_c) begin
            if (w_load_ok) begin
                w_nxt_ms_hr  = new_ms_hr;
                w_nxt_ls_hr  = new_ls_hr;
                w_nxt_ms_min = new_ms_min;
                w_nxt_ls_min = new_ls_min;
                w_nxt_ms_sec = SECONDS_EN ? new_ms_sec : DIG_W'(0);
                w_nxt_ls_sec = SECONDS_EN ? new_ls_sec : DIG_W'(0);
                w_nxt_pm     = HOUR_24 ? 1'b0 : new_pm;
            end else begin
                w_nxt_load_err = 1'b1;
            end
        end else if (tick) begin
            if (SECONDS_EN) begin
                if (r_ls_sec == DIG_W'(9)) begin
                    w_nxt_ls_sec = DIG_W'(0);
                    if (r_ms_sec == DIG_W'(5)) begin
                        w_nxt_ms_sec = DIG_W'(0);
                        w_min_step   = 1'b1;
                    end else begin
                        w_nxt_ms_sec = r_ms_sec + DIG_W'(1);
                    end
                end else begin
                    w_nxt_ls_sec = r_ls_sec + DIG_W'(1);
                end
            end else begin
                w_min_step = 1'b1;
            end
        end

        if (w_min_step) begin
            w_nxt_minute_pulse = 1'b1;
            if (r_ls_min == DIG_W'(9)) begin
                w_nxt_ls_min = DIG_W'(0);
                if (r_ms_min == DIG_W'(5)) begin
                    w_nxt_ms_min = DIG_W'(0);
                    w_hr_step    = 1'b1;
                end else begin
                    w_nxt_ms_min = r_ms_min + DIG_W'(1);
                end
            end else begin
                w_nxt_ls_min = r_ls_min + DIG_W'(1);
            end
        end

        if (w_hr_step) begin
            if (HOUR_24) begin
                if ((r_ms_hr == DIG_W'(2)) && (r_ls_hr == DIG_W'(3))) begin
                    w_nxt_ms_hr    = DIG_W'(0);
                    w_nxt_ls_hr    = DIG_W'(0);
                    w_nxt_day_wrap = 1'b1;
                end else if (r_ls_hr == DIG_W'(9)) begin
                    w_nxt_ms_hr = r_ms_hr + DIG_W'(1);
                    w_nxt_ls_hr = DIG_W'(0);
                end else begin
                    w_nxt_ls_hr = r_ls_hr + DIG_W'(1);
                end
            end else begin
                // 11 -> 12 flips AM/PM; only 11 PM -> 12 AM is a new day.
                if ((r_ms_hr == DIG_W'(1)) && (r_ls_hr == DIG_W'(1))) begin
                    w_nxt_ls_hr    = DIG_W'(2);
                    w_nxt_pm       = !r_pm;
                    w_nxt_day_wrap = r_pm;
                end else if ((r_ms_hr == DIG_W'(1)) && (r_ls_hr == DIG_W'(2))) begin
                    w_nxt_ms_hr = DIG_W'(0);
                    w_nxt_ls_hr = DIG_W'(1);
                end else if (r_ls_hr == DIG_W'(9)) begin
                    w_nxt_ms_hr = DIG_W'(1);
                    w_nxt_ls_hr = DIG_W'(0);
                end else begin
                    w_nxt_ls_hr = r_ls_hr + DIG_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms_hr        <= RST_MS_HR;
            r_ls_hr        <= RST_LS_HR;
            r_ms_min       <= DIG_W'(0);
            r_ls_min       <= DIG_W'(0);
            r_ms_sec       <= DIG_W'(0);
            r_ls_sec       <= DIG_W'(0);
            r_pm           <= 1'b0;
            r_minute_pulse <= 1'b0;
            r_day_wrap     <= 1'b0;
            r_load_err     <= 1'b0;
        end else begin
            r_ms_hr        <= w_nxt_ms_hr;
            r_ls_hr        <= w_nxt_ls_hr;
            r_ms_min       <= w_nxt_ms_min;
            r_ls_min       <= w_nxt_ls_min;
            r_ms_sec       <= w_nxt_ms_sec;
            r_ls_sec       <= w_nxt_ls_sec;
            r_pm           <= w_nxt_pm;
            r_minute_pulse <= w_nxt_minute_pulse;
            r_day_wrap     <= w_nxt_day_wrap;
            r_load_err     <= w_nxt_load_err;
        end
    end

    assign ms_hr        = r_ms_hr;
    assign ls_hr        = r_ls_hr;
    assign ms_min       = r_ms_min;
    assign ls_min       = r_ls_min;
    assign ms_sec       = r_ms_sec;
    assign ls_sec       = r_ls_sec;
    assign pm           = r_pm;
    assign minute_pulse = r_minute_pulse;
    assign day_wrap     = r_day_wrap;
    assign load_err     = r_load_err;

endmodule

// File: tb/tb_rtc_time_counter.sv
// Bench for rtc_time_counter: three parameterisations share stimulus; each is
// checked against a seconds-of-day reference model plus directed constants.
module tb_rtc_time_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, tick, load_new_c, new_pm;
    logic [3:0] n_mh, n_lh, n_mm, n_lm, n_ms, n_ls;

    logic [3:0] o_mh[3], o_lh[3], o_mm[3], o_lm[3], o_ms[3], o_ls[3];
    logic       o_pm[3], o_mp[3], o_dw[3], o_le[3];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: time kept as seconds since midnight.
    int tod[3];
    bit m_mp[3], m_dw[3], m_le[3];

    rtc_time_counter #(.SECONDS_EN(1'b1), .HOUR_24(1'b1)) u0 (
        .clk(clk), .reset(reset), .tick(tick), .load_new_c(load_new_c),
        .new_ms_hr(n_mh), .new_ls_hr(n_lh), .new_ms_min(n_mm), .new_ls_min(n_lm),
        .new_ms_sec(n_ms), .new_ls_sec(n_ls), .new_pm(new_pm),
        .ms_hr(o_mh[0]), .ls_hr(o_lh[0]), .ms_min(o_mm[0]), .ls_min(o_lm[0]),
        .ms_sec(o_ms[0]), .ls_sec(o_ls[0]), .pm(o_pm[0]),
        .minute_pulse(o_mp[0]), .day_wrap(o_dw[0]), .load_err(o_le[0]));

    rtc_time_counter #(.SECONDS_EN(1'b1), .HOUR_24(1'b0)) u1 (
        .clk(clk), .reset(reset), .tick(tick), .load_new_c(load_new_c),
        .new_ms_hr(n_mh), .new_ls_hr(n_lh), .new_ms_min(n_mm), .new_ls_min(n_lm),
        .new_ms_sec(n_ms), .new_ls_sec(n_ls), .new_pm(new_pm),
        .ms_hr(o_mh[1]), .ls_hr(o_lh[1]), .ms_min(o_mm[1]), .ls_min(o_lm[1]),
        .ms_sec(o_ms[1]), .ls_sec(o_ls[1]), .pm(o_pm[1]),
        .minute_pulse(o_mp[1]), .day_wrap(o_dw[1]), .load_err(o_le[1]));

    rtc_time_counter #(.SECONDS_EN(1'b0), .HOUR_24(1'b1)) u2 (
        .clk(clk), .reset(reset), .tick(tick), .load_new_c(load_new_c),
        .new_ms_hr(n_mh), .new_ls_hr(n_lh), .new_ms_min(n_mm), .new_ls_min(n_lm),
        .new_ms_sec(n_ms), .new_ls_sec(n_ls), .new_pm(new_pm),
        .ms_hr(o_mh[2]), .ls_hr(o_lh[2]), .ms_min(o_mm[2]), .ls_min(o_lm[2]),
        .ms_sec(o_ms[2]), .ls_sec(o_ls[2]), .pm(o_pm[2]),
        .minute_pulse(o_mp[2]), .day_wrap(o_dw[2]), .load_err(o_le[2]));

    function automatic bit sec_en(int k); return k != 2; endfunction
    function automatic bit h24(int k);    return k != 1; endfunction

    function automatic logic [28:0] obs(int k);
        return {o_mh[k], o_lh[k], o_mm[k], o_lm[k], o_ms[k], o_ls[k],
                o_pm[k], o_mp[k], o_dw[k], o_le[k]};
    endfunction

    // Display vector from plain decimal fields.
    function automatic logic [28:0] tv(int hh, int mm, int ss, bit p, bit mp, bit dw, bit le);
        return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10),
                4'(ss / 10), 4'(ss % 10), p, mp, dw, le};
    endfunction

    function automatic logic [28:0] exp_vec(int k);
        int h, m, s, dh;
        bit p;
        h = tod[k] / 3600;
        m = (tod[k] / 60) % 60;
        s = tod[k] % 60;
        if (h24(k)) begin
            dh = h; p = 1'b0;
        end else begin
            dh = (h % 12 == 0) ? 12 : h % 12;
            p  = (h >= 12);
        end
        return tv(dh, m, s, p, m_mp[k], m_dw[k], m_le[k]);
    endfunction

    function automatic bit load_valid(int k);
        int hv;
        hv = int'(n_mh) * 10 + int'(n_lh);
        if (n_lh > 4'd9 || n_lm > 4'd9 || n_mm > 4'd5) return 1'b0;
        if (sec_en(k) && (n_ls > 4'd9 || n_ms > 4'd5)) return 1'b0;
        if (h24(k)) return hv <= 23;
        return hv >= 1 && hv <= 12;
    endfunction

    function automatic int load_tod(int k);
        int hv, h, mv, sv;
        hv = int'(n_mh) * 10 + int'(n_lh);
        mv = int'(n_mm) * 10 + int'(n_lm);
        sv = sec_en(k) ? int'(n_ms) * 10 + int'(n_ls) : 0;
        if (h24(k)) h = hv;
        else        h = (hv == 12 ? 0 : hv) + (new_pm ? 12 : 0);
        return h * 3600 + mv * 60 + sv;
    endfunction

    task automatic model_step();
        int nt;
        for (int k = 0; k < 3; k++) begin
            m_mp[k] = 1'b0; m_dw[k] = 1'b0; m_le[k] = 1'b0;
            if (reset) begin
                tod[k] = 0;
            end else if (load_new_c) begin
                if (load_valid(k)) tod[k] = load_tod(k);
                else               m_le[k] = 1'b1;
            end else if (tick) begin
                nt      = (tod[k] + (sec_en(k) ? 1 : 60)) % 86400;
                m_mp[k] = (nt / 60) != (tod[k] / 60);
                m_dw[k] = nt < tod[k];
                tod[k]  = nt;
            end
        end
    endtask

    task automatic cycle(bit r, bit ld, bit tk);
        reset = r; load_new_c = ld; tick = tk;
        @(posedge clk);
        model_step();
        #1;
        reset = 1'b0; load_new_c = 1'b0; tick = 1'b0;
    endtask

    task automatic set_digits(int hh, int mm, int ss, bit p);
        n_mh = 4'(hh / 10); n_lh = 4'(hh % 10);
        n_mm = 4'(mm / 10); n_lm = 4'(mm % 10);
        n_ms = 4'(ss / 10); n_ls = 4'(ss % 10);
        new_pm = p;
    endtask

    task automatic test_reset();
        logic [28:0] e;
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1);
        e = tv(0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (obs(0) !== e) begin n_fail++; $display("FAIL reset_24h: got %h expected %h", obs(0), e); end
        e = tv(12, 0, 0, 0, 0, 0, 0);
        n_checks++; if (obs(1) !== e) begin n_fail++; $display("FAIL reset_12h: got %h expected %h", obs(1), e); end
        e = tv(0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (obs(2) !== e) begin n_fail++; $display("FAIL reset_nosec: got %h expected %h", obs(2), e); end
    endtask

    task automatic test_wrap24();
        logic [28:0] e;
        set_digits(23, 59, 58, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        e = tv(23, 59, 58, 0, 0, 0, 0);
        n_checks++; if (obs(0) !== e) begin n_fail++; $display("FAIL wrap_load: got %h expected %h", obs(0), e); end
        cycle(1'b0, 1'b0, 1'b1);
        e = tv(23, 59, 59, 0, 0, 0, 0);
        n_checks++; if (obs(0) !== e) begin n_fail++; $display("FAIL wrap_t1: got %h expected %h", obs(0), e); end
        cycle(1'b0, 1'b0, 1'b1);
        e = tv(0, 0, 0, 0, 1, 1, 0);
        n_checks++; if (obs(0) !== e) begin n_fail++; $display("FAIL wrap_t2: got %h expected %h", obs(0), e); end
        cycle(1'b0, 1'b0, 1'b0);
        e = tv(0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (obs(0) !== e) begin n_fail++; $display("FAIL wrap_pulse_end: got %h expected %h", obs(0), e); end
    endtask

    task automatic test_12h();
        logic [28:0] e;
        set_digits(11, 59, 59, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        e = tv(12, 0, 0, 1, 1, 0, 0);
        n_checks++; if (obs(1) !== e) begin n_fail++; $display("FAIL h12_am_to_pm: got %h expected %h", obs(1), e); end
        set_digits(11, 59, 59, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        e = tv(12, 0, 0, 0, 1, 1, 0);
        n_checks++; if (obs(1) !== e) begin n_fail++; $display("FAIL h12_midnight: got %h expected %h", obs(1), e); end
        set_digits(12, 59, 59, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        e = tv(1, 0, 0, 0, 1, 0, 0);
        n_checks++; if (obs(1) !== e) begin n_fail++; $display("FAIL h12_12_to_1: got %h expected %h", obs(1), e); end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs(k) !== exp_vec(k)) begin n_fail++; $display("FAIL h12_model dut%0d: got %h expected %h", k, obs(k), exp_vec(k)); end
        end
    endtask

    task automatic test_invalid();
        logic [28:0] e;
        set_digits(10, 15, 0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        set_digits(10, 15, 0, 1'b0); n_lm = 4'hF;
        cycle(1'b0, 1'b1, 1'b0);
        e = tv(10, 15, 0, 0, 0, 0, 1);
        n_checks++; if (obs(0) !== e) begin n_fail++; $display("FAIL inv_lsmin: got %h expected %h", obs(0), e); end
        set_digits(10, 65, 0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        n_checks++; if (obs(0) !== e) begin n_fail++; $display("FAIL inv_msmin: got %h expected %h", obs(0), e); end
        set_digits(24, 15, 0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        n_checks++; if (obs(0) !== e) begin n_fail++; $display("FAIL inv_hr24: got %h expected %h", obs(0), e); end
        cycle(1'b0, 1'b0, 1'b0);
        e = tv(10, 15, 0, 0, 0, 0, 0);
        n_checks++; if (obs(0) !== e) begin n_fail++; $display("FAIL inv_err_oneshot: got %h expected %h", obs(0), e); end
        set_digits(0, 15, 0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        e = tv(10, 15, 0, 0, 0, 0, 1);
        n_checks++; if (obs(1) !== e) begin n_fail++; $display("FAIL inv_hr00_12h: got %h expected %h", obs(1), e); end
        e = tv(0, 15, 0, 0, 0, 0, 0);
        n_checks++; if (obs(0) !== e) begin n_fail++; $display("FAIL hr00_ok_24h: got %h expected %h", obs(0), e); end
    endtask

    task automatic test_load_tick();
        logic [28:0] e;
        set_digits(3, 27, 44, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        set_digits(10, 15, 0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        e = tv(10, 15, 0, 0, 0, 0, 0);
        n_checks++; if (obs(0) !== e) begin n_fail++; $display("FAIL ldtick_load: got %h expected %h", obs(0), e); end
        n_checks++; if (obs(2) !== e) begin n_fail++; $display("FAIL ldtick_load_nosec: got %h expected %h", obs(2), e); end
        cycle(1'b0, 1'b0, 1'b1);
        e = tv(10, 15, 1, 0, 0, 0, 0);
        n_checks++; if (obs(0) !== e) begin n_fail++; $display("FAIL ldtick_next: got %h expected %h", obs(0), e); end
        e = tv(10, 16, 0, 0, 1, 0, 0);
        n_checks++; if (obs(2) !== e) begin n_fail++; $display("FAIL ldtick_next_nosec: got %h expected %h", obs(2), e); end
    endtask

    task automatic test_sec_off();
        logic [28:0] e;
        set_digits(9, 59, 37, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        e = tv(9, 59, 0, 0, 0, 0, 0);
        n_checks++; if (obs(2) !== e) begin n_fail++; $display("FAIL nosec_load: got %h expected %h", obs(2), e); end
        cycle(1'b0, 1'b0, 1'b1);
        e = tv(10, 0, 0, 0, 1, 0, 0);
        n_checks++; if (obs(2) !== e) begin n_fail++; $display("FAIL nosec_tick: got %h expected %h", obs(2), e); end
        set_digits(23, 59, 59, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        e = tv(0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (obs(2) !== e) begin n_fail++; $display("FAIL rst_tick_nosec: got %h expected %h", obs(2), e); end
        n_checks++; if (obs(0) !== e) begin n_fail++; $display("FAIL rst_tick_24h: got %h expected %h", obs(0), e); end
        set_digits(24, 70, 70, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        e = tv(12, 0, 0, 0, 0, 0, 0);
        n_checks++; if (obs(1) !== e) begin n_fail++; $display("FAIL rst_badload_12h: got %h expected %h", obs(1), e); end
    endtask

    task automatic test_random();
        int r, hh, mm, ss;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 7) == 0) begin
                n_mh = 4'($urandom_range(0, 15)); n_lh = 4'($urandom_range(0, 15));
                n_mm = 4'($urandom_range(0, 15)); n_lm = 4'($urandom_range(0, 15));
                n_ms = 4'($urandom_range(0, 15)); n_ls = 4'($urandom_range(0, 15));
                new_pm = 1'($urandom_range(0, 1));
            end else begin
                case ($urandom_range(0, 3))
                    0:       hh = 23;
                    1:       hh = 11;
                    2:       hh = 12;
                    default: hh = $urandom_range(0, 23);
                endcase
                mm = ($urandom_range(0, 1) == 0) ? 59 : $urandom_range(0, 59);
                ss = $urandom_range(50, 59);
                set_digits(hh, mm, ss, 1'($urandom_range(0, 1)));
            end
            cycle(r < 2, (r >= 2) && (r < 12), $urandom_range(0, 3) != 0);
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (obs(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL random_%0d dut%0d: got %h expected %h", i, k, obs(k), exp_vec(k));
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0; tick = 1'b0; load_new_c = 1'b0;
        set_digits(0, 0, 0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tod[k] = 0; m_mp[k] = 1'b0; m_dw[k] = 1'b0; m_le[k] = 1'b0;
        end
        test_reset();
        test_wrap24();
        test_12h();
        test_invalid();
        test_load_tick();
        test_sec_off();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
